// File: rtl/sa_tile_arbiter_if.sv
// Request/grant and beat-issue bundle between tile requesters, the tile arbiter
// and the systolic array input path.
interface sa_tile_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ROWS    = 4,
  parameter int WID_W   = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WID_W-1:0] req_wid;
  logic                     fifo_has_space;
  logic                     drained;
  logic [NUM_REQ-1:0]       gnt;
  logic                     gnt_pulse;
  logic                     weight_enable;
  logic                     input_enable;
  logic [$clog2(ROWS)-1:0]  row_sel;
  logic                     new_weight;
  logic                     tile_done;

  modport master (
    output req_valid, req_wid, fifo_has_space, drained,
    input  gnt, gnt_pulse, weight_enable, input_enable, row_sel, new_weight, tile_done
  );

  modport slave (
    input  req_valid, req_wid, fifo_has_space, drained,
    output gnt, gnt_pulse, weight_enable, input_enable, row_sel, new_weight, tile_done
  );
endinterface

// File: rtl/sa_tile_arbiter.sv
// Round-robin owner arbitration for a systolic array: weight load, input stream, drain.
// Optional macro SA_ARB_WEIGHT_REUSE_EN skips the weight load when the weight set is already resident.
module sa_tile_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROWS    = 4,
  parameter int WID_W   = 8
) (
  input logic             CLK,
  input logic             nRST,
  sa_tile_arbiter_if.slave arb
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [NUM_REQ-1:0] gnt_r;
  logic               gnt_pulse_r;
  logic               new_weight_r;
  logic               tile_done_r;
  logic [ROW_W-1:0]   row_sel_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   sel_s;
  logic               found_s;
  logic               need_load_s;
  logic               last_row_s;
  logic               weight_enable_s;
  logic               input_enable_s;

  assign last_row_s = (row_sel_r == ROW_W'(ROWS - 1));

  // Pick the first pending requester at or after rr_ptr, wrapping cyclically.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             hit;
    found_s = 1'b0;
    sel_s   = rr_ptr_r;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand    = rr_ptr_r + IDX_W'(k);
      hit     = arb.req_valid[cand] && !found_s;
      sel_s   = hit ? cand : sel_s;
      found_s = found_s | hit;
    end
  end

`ifdef SA_ARB_WEIGHT_REUSE_EN
  logic               last_valid_r;
  logic [WID_W-1:0]   last_wid_r;
  logic [WID_W-1:0]   tile_wid_r;
  logic [WID_W-1:0]   sel_wid_s;

  assign sel_wid_s   = arb.req_wid[sel_s*WID_W +: WID_W];
  assign need_load_s = !(last_valid_r && (sel_wid_s == last_wid_r));

  // The tile's ID is frozen at grant so later req_wid changes cannot leak in.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last_valid_r <= 1'b0;
      last_wid_r   <= '0;
      tile_wid_r   <= '0;
    end else if (state_r == IDLE && found_s) begin
      tile_wid_r <= sel_wid_s;
    end else if (state_r == LOAD && arb.fifo_has_space && last_row_s) begin
      last_wid_r   <= tile_wid_r;
      last_valid_r <= 1'b1;
    end
  end
`else
  logic unused_wid_s;

  // Without reuse every tile reloads, so the weight-set IDs are irrelevant.
  assign unused_wid_s = ^arb.req_wid;
  assign need_load_s  = 1'b1;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_s = need_load_s ? LOAD : STREAM;
        else         state_s = IDLE;
      end
      LOAD: begin
        if (arb.fifo_has_space && last_row_s) state_s = STREAM;
        else                                  state_s = LOAD;
      end
      STREAM: begin
        if (arb.fifo_has_space && last_row_s) state_s = DRAIN;
        else                                  state_s = STREAM;
      end
      DRAIN: begin
        if (arb.drained) state_s = IDLE;
        else             state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Beat strobes follow the current cycle's fifo space so a stall never issues a beat.
  always_comb begin
    weight_enable_s = 1'b0;
    input_enable_s  = 1'b0;
    if (nRST) begin
      weight_enable_s = (state_r == LOAD)   && arb.fifo_has_space;
      input_enable_s  = (state_r == STREAM) && arb.fifo_has_space;
    end else begin
      weight_enable_s = 1'b0;
      input_enable_s  = 1'b0;
    end
  end

  // Grant ownership, row counter and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      gnt_r        <= '0;
      gnt_pulse_r  <= 1'b0;
      new_weight_r <= 1'b0;
      tile_done_r  <= 1'b0;
      row_sel_r    <= '0;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
    end else begin
      gnt_pulse_r <= 1'b0;
      tile_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt_r        <= NUM_REQ'(1) << sel_s;
            owner_r      <= sel_s;
            gnt_pulse_r  <= 1'b1;
            new_weight_r <= need_load_s;
            row_sel_r    <= '0;
          end
        end
        LOAD, STREAM: begin
          if (arb.fifo_has_space) begin
            row_sel_r <= last_row_s ? '0 : row_sel_r + ROW_W'(1);
          end
        end
        DRAIN: begin
          if (arb.drained) begin
            tile_done_r  <= 1'b1;
            gnt_r        <= '0;
            new_weight_r <= 1'b0;
            rr_ptr_r     <= owner_r + IDX_W'(1);
          end
        end
        default: begin
          gnt_r <= '0;
        end
      endcase
    end
  end

  assign arb.gnt           = gnt_r;
  assign arb.gnt_pulse     = gnt_pulse_r;
  assign arb.weight_enable = weight_enable_s;
  assign arb.input_enable  = input_enable_s;
  assign arb.row_sel       = row_sel_r;
  assign arb.new_weight    = new_weight_r;
  assign arb.tile_done     = tile_done_r;
endmodule
